// File: rtl/servisia_gpio_ctrl.sv
// Wishbone GPIO: per-pin direction, synchronised inputs, atomic SET/CLR/TGL, rise/fall edge IRQs.
// Ack one cycle after stb is sampled and at most every other cycle; the held stb is the only stall.
module servisia_gpio_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_rdt_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam logic [3:0] ADR_DATA_OUT = 4'd0;
    localparam logic [3:0] ADR_SET      = 4'd1;
    localparam logic [3:0] ADR_CLR      = 4'd2;
    localparam logic [3:0] ADR_TGL      = 4'd3;
    localparam logic [3:0] ADR_DIR      = 4'd4;
    localparam logic [3:0] ADR_DATA_IN  = 4'd5;
    localparam logic [3:0] ADR_RISE_EN  = 4'd6;
    localparam logic [3:0] ADR_FALL_EN  = 4'd7;
    localparam logic [3:0] ADR_IRQ_STAT = 4'd8;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;

    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rd_val;
    logic             access;
    logic             wr;
    logic             unused_bits;

    // Upper data/sel bits are legitimately ignored when WIDTH < 32.
    assign unused_bits = ^{wb_dat_i, wb_sel_i};

    assign in_s   = sync_q[SYNC_STAGES-1];
    assign rise   = in_s & ~prev_q;
    assign fall   = ~in_s & prev_q;
    assign access = wb_stb_i & ~ack_q;
    assign wr     = access & wb_we_i;
    assign ack_d  = access;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wmask[i] = wb_sel_i[i/8];
        end
        wd = wb_dat_i[WIDTH-1:0] & wmask;
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr) begin
            case (wb_adr_i)
                ADR_DATA_OUT: out_d     = (out_q & ~wmask) | wd;
                ADR_SET:      out_d     = out_q | wd;
                ADR_CLR:      out_d     = out_q & ~wd;
                ADR_TGL:      out_d     = out_q ^ wd;
                ADR_DIR:      dir_d     = (dir_q & ~wmask) | wd;
                ADR_RISE_EN:  rise_en_d = (rise_en_q & ~wmask) | wd;
                ADR_FALL_EN:  fall_en_d = (fall_en_q & ~wmask) | wd;
                ADR_IRQ_STAT: w1c       = wd;
                default:      ;
            endcase
        end
        // New edge events are OR-ed in after the clear, so a coincident set wins.
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        case (wb_adr_i)
            ADR_DATA_OUT: rd_val = out_q;
            ADR_DIR:      rd_val = dir_q;
            ADR_DATA_IN:  rd_val = in_s;
            ADR_RISE_EN:  rd_val = rise_en_q;
            ADR_FALL_EN:  rd_val = fall_en_q;
            ADR_IRQ_STAT: rd_val = status_q;
            default:      rd_val = '0;
        endcase
        rdt_d = rdt_q;
        if (access) begin
            rdt_d              = '0;
            rdt_d[WIDTH-1:0]   = rd_val;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= in_s;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_rdt_o  = rdt_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |status_q;

endmodule

// File: tb/tb_servisia_gpio_ctrl.sv
// Directed bench for servisia_gpio_ctrl with a bus scoreboard checked on every ack.
module tb_servisia_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    servisia_gpio_ctrl #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .RESET_OUT   (16'h00A5)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_stb_i  (stb),
        .wb_rdt_o  (rdt),
        .wb_ack_o  (ack),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    typedef struct {
        int          id;
        logic        chk_rdt;
        logic [31:0] rdt;
        logic        chk_gpio;
        logic [15:0] gpio;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   acc_id = 0;
    bit   prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            chk("ack_not_back_to_back", {31'b0, prev_ack}, 32'h0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk_rdt)  chk($sformatf("bus_rdt#%0d", e.id), rdt, e.rdt);
                if (e.chk_gpio) chk($sformatf("bus_gpio#%0d", e.id), {16'h0, gpio_out}, {16'h0, e.gpio});
            end
        end
        prev_ack = (ack === 1'b1);
    end

    // Caller is at a negedge; returns at the negedge that observes the ack.
    task automatic wb(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                      input logic crd, input logic [31:0] erd, input logic cg, input logic [15:0] eg);
        exp_t e;
        bit   got;
        e.id = acc_id; e.chk_rdt = crd; e.rdt = erd; e.chk_gpio = cg; e.gpio = eg;
        acc_id++;
        sb_q.push_back(e);
        adr = a; dat = d; sel = s; we = w; stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        stb = 1'b0; we = 1'b0;
        if (!got) begin
            chk($sformatf("ack_timeout#%0d", e.id), 32'h0, 32'h1);
            e = sb_q.pop_back();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [15:0] eg);
        wb(a, d, s, 1'b1, 1'b0, 32'h0, 1'b1, eg);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] erd);
        wb(a, 32'h0, 4'hF, 1'b0, 1'b1, erd, 1'b0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0; gpio_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_o", {16'h0, gpio_out}, 32'h0000_00A5);
        chk("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_rdt", rdt, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rd(4'd0, 32'h0000_00A5);

        // Atomic set/clear/toggle from A5
        wr(4'd1, 32'h0F, 4'hF, 16'h00AF);
        wr(4'd2, 32'h81, 4'hF, 16'h002E);
        wr(4'd3, 32'hFF, 4'hF, 16'h00D1);
        rd(4'd1, 32'h0);
        rd(4'd3, 32'h0);

        // Byte enables, reserved space, upper bits read zero
        wr(4'd0, 32'h0, 4'hF, 16'h0000);
        wr(4'd0, 32'h1234, 4'b0010, 16'h1200);
        rd(4'd0, 32'h0000_1200);
        rd(4'd9, 32'h0);
        wr(4'd9, 32'hFFFF_FFFF, 4'hF, 16'h1200);
        rd(4'd9, 32'h0);
        wr(4'd1, 32'h0000_0034, 4'b0010, 16'h1200);
        wr(4'd0, 32'hFFFF_FFFF, 4'hF, 16'hFFFF);
        rd(4'd0, 32'h0000_FFFF);
        wr(4'd4, 32'h0000_00FF, 4'hF, 16'hFFFF);
        chk("dir_oe", {16'h0, gpio_oe}, 32'h0000_00FF);
        rd(4'd4, 32'h0000_00FF);

        // Rising edge on pin0: irq on the third edge after the pin change
        wr(4'd6, 32'h1, 4'hF, 16'hFFFF);
        gpio_in[0] = 1'b1;
        @(negedge clk); chk("rise_irq_edge1", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("rise_irq_edge2", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("rise_irq_edge3", {31'h0, irq}, 32'h1);
        rd(4'd5, 32'h0000_0001);
        rd(4'd8, 32'h0000_0001);
        wr(4'd8, 32'h1, 4'hF, 16'hFFFF);
        chk("w1c_irq_low", {31'h0, irq}, 32'h0);

        // Falling edge on pin1 coinciding with its W1C: set wins
        gpio_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("pin1_high_no_irq", {31'h0, irq}, 32'h0);
        wr(4'd7, 32'h2, 4'hF, 16'hFFFF);
        gpio_in[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr(4'd8, 32'h2, 4'hF, 16'hFFFF);
        chk("set_wins_irq", {31'h0, irq}, 32'h1);
        rd(4'd8, 32'h0000_0002);
        wr(4'd7, 32'h0, 4'hF, 16'hFFFF);
        chk("en_clear_keeps_pending", {31'h0, irq}, 32'h1);
        rd(4'd8, 32'h0000_0002);
        wr(4'd8, 32'h2, 4'hF, 16'hFFFF);
        chk("w1c_pin1_irq_low", {31'h0, irq}, 32'h0);

        // Held stb for six cycles: three acks, never adjacent
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.id = acc_id; e.chk_rdt = 1'b1; e.rdt = 32'h0000_FFFF; e.chk_gpio = 1'b1; e.gpio = 16'hFFFF;
            acc_id++;
            sb_q.push_back(e);
        end
        adr = 4'd0; we = 1'b0; sel = 4'hF; stb = 1'b1;
        repeat (6) @(negedge clk);
        stb = 1'b0;
        chk("held_stb_three_acks", sb_q.size(), 32'h0);
        sb_q.delete();

        // Reset together with a write: no ack, write lost
        @(negedge clk);
        adr = 4'd0; dat = 32'h0000_1111; sel = 4'hF; we = 1'b1; stb = 1'b1; rst = 1'b1;
        @(negedge clk); chk("rst_mid_ack1", {31'h0, ack}, 32'h0);
        @(negedge clk); chk("rst_mid_ack2", {31'h0, ack}, 32'h0);
        stb = 1'b0; we = 1'b0; rst = 1'b0;
        chk("rst_mid_gpio", {16'h0, gpio_out}, 32'h0000_00A5);
        chk("rst_mid_oe", {16'h0, gpio_oe}, 32'h0);
        @(negedge clk);
        chk("rst_mid_gpio_after", {16'h0, gpio_out}, 32'h0000_00A5);
        rd(4'd0, 32'h0000_00A5);
        rd(4'd5, 32'h0000_0001);

        @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
